div_issue_ctrl: RTL and testbench

- Sequences a shared fixed-latency pipelined 32-bit divider core between two requesters (A, B).
- Round-robin arbitration; tags each operation with its source in a LATENCY-deep valid/tag shadow pipeline.
- Stalls the core via its clock enable when the result consumer back-pressures.
- Flags divide-by-zero.
- Sits between the ALU issue logic and the divider core instance.

---
 rtl/div_issue_ctrl.sv | 151 +++++++++++++++
 tb/tb_div_issue_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : div_issue_ctrl
//  Description : Round-robin issue controller for a shared fixed-latency
//                pipelined divider core. Tags each op with its source in a
//                shadow pipeline, stalls the core on result back-pressure
//                and substitutes a divide-by-zero result.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_issue_ctrl #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 8
) (
    input  logic             CLK,
    input  logic             RST,
    // requester A
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_op1,
    input  logic [WIDTH-1:0] a_op2,
    // requester B
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [WIDTH-1:0] b_op1,
    input  logic [WIDTH-1:0] b_op2,
    // divider core
    output logic             core_ce,
    input  logic             core_rfd,
    output logic [WIDTH-1:0] core_dividend,
    output logic [WIDTH-1:0] core_divisor,
    input  logic [WIDTH-1:0] core_quotient,
    input  logic [WIDTH-1:0] core_fractional,
    // result consumer
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_quotient,
    output logic [WIDTH-1:0] res_fractional,
    output logic             res_src,
    output logic             res_div0,
    output logic             busy
);

    localparam logic c_SRC_A = 1'b0;

    // round-robin pointer: which requester wins when both are valid
    logic               r_rr_ptr;
    // shadow pipeline mirroring the core's internal stages
    logic [LATENCY-1:0] r_vld;
    logic [LATENCY-1:0] r_src;
    logic [LATENCY-1:0] r_div0;
    logic [WIDTH-1:0]   r_dvd [LATENCY];

    logic               w_stall;
    logic               w_issue_ok;
    logic               w_grant_a;
    logic               w_grant_b;
    logic               w_grant;
    logic [WIDTH-1:0]   w_op1;
    logic [WIDTH-1:0]   w_op2;
    logic               w_op2_zero;

    // The whole pipe freezes while a presented result is not taken
    assign w_stall    = res_valid & ~res_ready;
    assign core_ce    = ~w_stall;
    assign w_issue_ok = core_ce & core_rfd;

    // Arbitration: a lone requester wins; on contention the pointer decides
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (w_issue_ok) begin
            w_grant_a = a_valid & (~b_valid | (r_rr_ptr == c_SRC_A));
            w_grant_b = b_valid & (~a_valid | (r_rr_ptr != c_SRC_A));
        end
    end

    assign w_grant = w_grant_a | w_grant_b;
    assign a_ready = w_grant_a;
    assign b_ready = w_grant_b;

    // Operand mux; idle cycles feed 0/1 so the core never sees a zero divisor
    always_comb begin
        w_op1 = '0;
        w_op2 = {{(WIDTH-1){1'b0}}, 1'b1};
        if (w_grant_a) begin
            w_op1 = a_op1;
            w_op2 = a_op2;
        end else if (w_grant_b) begin
            w_op1 = b_op1;
            w_op2 = b_op2;
        end
    end

    assign w_op2_zero    = (w_op2 == '0);
    assign core_dividend = w_op1;
    assign core_divisor  = w_op2;

    // Pointer moves to the loser of every actual grant
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rr_ptr <= c_SRC_A;
        end else if (w_grant) begin
            r_rr_ptr <= w_grant_a;
        end
    end

    // Control part of the shadow pipeline; advances in lock-step with the core
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_vld  <= '0;
            r_src  <= '0;
            r_div0 <= '0;
        end else if (core_ce) begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                r_vld[i]  <= r_vld[i-1];
                r_src[i]  <= r_src[i-1];
                r_div0[i] <= r_div0[i-1];
            end
            r_vld[0]  <= w_grant;
            r_src[0]  <= w_grant_b;
            r_div0[0] <= w_grant & w_op2_zero;
        end
    end

    // Dividend carried alongside; only its valid-qualified copy is ever used
    always_ff @(posedge CLK) begin
        if (core_ce) begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                r_dvd[i] <= r_dvd[i-1];
            end
            r_dvd[0] <= w_op1;
        end
    end

    assign res_valid = r_vld[LATENCY-1];
    assign res_src   = r_src[LATENCY-1];
    assign res_div0  = r_div0[LATENCY-1];
    assign busy      = |r_vld;

    // Divide-by-zero overrides whatever the core produced
    always_comb begin
        res_quotient   = core_quotient;
        res_fractional = core_fractional;
        if (r_div0[LATENCY-1]) begin
            res_quotient   = '1;
            res_fractional = r_dvd[LATENCY-1];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_issue_ctrl
//  Description : Directed self-checking bench for div_issue_ctrl with a
//                behavioural fixed-latency divider core stand-in.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_div_issue_ctrl;

    localparam int W   = 32;
    localparam int LAT = 4;

    logic         CLK = 1'b0;
    logic         RST;
    logic         a_valid, b_valid, a_ready, b_ready;
    logic [W-1:0] a_op1, a_op2, b_op1, b_op2;
    logic         core_ce, core_rfd;
    logic [W-1:0] core_dividend, core_divisor, core_quotient, core_fractional;
    logic         res_valid, res_ready, res_src, res_div0, busy;
    logic [W-1:0] res_quotient, res_fractional;

    int checks = 0;
    int errors = 0;

    div_issue_ctrl #(.WIDTH(W), .LATENCY(LAT)) dut (
        .CLK(CLK), .RST(RST),
        .a_valid(a_valid), .a_ready(a_ready), .a_op1(a_op1), .a_op2(a_op2),
        .b_valid(b_valid), .b_ready(b_ready), .b_op1(b_op1), .b_op2(b_op2),
        .core_ce(core_ce), .core_rfd(core_rfd),
        .core_dividend(core_dividend), .core_divisor(core_divisor),
        .core_quotient(core_quotient), .core_fractional(core_fractional),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_quotient(res_quotient), .res_fractional(res_fractional),
        .res_src(res_src), .res_div0(res_div0), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // Behavioural divider core: LAT register stages, frozen when core_ce=0
    logic [W-1:0] m_dvd [LAT];
    logic [W-1:0] m_dvs [LAT];

    initial begin
        for (int i = 0; i < LAT; i++) begin
            m_dvd[i] = '0;
            m_dvs[i] = 1;
        end
    end

    always @(posedge CLK) begin
        if (core_ce) begin
            for (int i = LAT - 1; i > 0; i--) begin
                m_dvd[i] <= m_dvd[i-1];
                m_dvs[i] <= m_dvs[i-1];
            end
            m_dvd[0] <= core_dividend;
            m_dvs[0] <= core_divisor;
        end
    end

    always_comb begin
        core_quotient   = '0;
        core_fractional = '0;
        if (m_dvs[LAT-1] != 0) begin
            core_quotient   = m_dvd[LAT-1] / m_dvs[LAT-1];
            core_fractional = m_dvd[LAT-1] % m_dvs[LAT-1];
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        a_valid = 0; b_valid = 0;
        step();
        step();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        a_valid = 0; b_valid = 0;
        a_op1 = 0; a_op2 = 1; b_op1 = 0; b_op2 = 1;
        core_rfd = 1; res_ready = 1;
        #2;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %0b exp 0", res_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        checks++; if (res_src !== 1'b0) begin errors++; $display("FAIL reset_res_src got %0b exp 0", res_src); end
        checks++; if (res_div0 !== 1'b0) begin errors++; $display("FAIL reset_res_div0 got %0b exp 0", res_div0); end
        checks++; if (core_ce !== 1'b1) begin errors++; $display("FAIL reset_core_ce got %0b exp 1", core_ce); end
        step();
        step();
        RST = 1'b0;
    endtask

    task automatic test_single();
        a_valid = 1; a_op1 = 100; a_op2 = 7;
        #1;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL single_a_ready got %0b exp 1", a_ready); end
        step();
        a_valid = 0;
        for (int k = 1; k <= LAT; k++) begin
            if (k > 1) step();
            if (k < LAT) begin
                checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid cycle %0d got %0b exp 0", k, res_valid); end
            end
        end
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b exp 1", res_valid); end
        checks++; if (res_quotient !== 14) begin errors++; $display("FAIL single_quotient got %0d exp 14", res_quotient); end
        checks++; if (res_fractional !== 2) begin errors++; $display("FAIL single_fractional got %0d exp 2", res_fractional); end
        checks++; if (res_src !== 1'b0 || res_div0 !== 1'b0) begin errors++; $display("FAIL single_tags got src %0b div0 %0b exp 0 0", res_src, res_div0); end
        step();
        checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_one_cycle got valid %0b busy %0b exp 0 0", res_valid, busy); end
    endtask

    task automatic test_contention();
        int a1 [6] = '{100, 110, 120, 130, 140, 150};
        int b1 [6] = '{210, 220, 230, 240, 250, 260};
        int eq [6] = '{33, 31, 40, 34, 46, 37};
        int er [6] = '{1, 3, 0, 2, 2, 1};
        int n = 0;
        do_reset();
        for (int t = 0; t < 20; t++) begin
            if (res_valid === 1'b1) begin
                if (n < 6) begin
                    checks++;
                    if (res_quotient !== eq[n] || res_fractional !== er[n] || res_src !== n[0]) begin
                        errors++;
                        $display("FAIL contention_result %0d got q=%0d r=%0d src=%0b exp q=%0d r=%0d src=%0b",
                                 n, res_quotient, res_fractional, res_src, eq[n], er[n], n[0]);
                    end
                end
                n++;
            end
            if (t < 6) begin
                a_valid = 1; a_op1 = a1[t]; a_op2 = 3;
                b_valid = 1; b_op1 = b1[t]; b_op2 = 7;
                #1;
                checks++;
                if (a_ready !== (t[0] == 1'b0) || b_ready !== (t[0] == 1'b1)) begin
                    errors++;
                    $display("FAIL contention_grant cycle %0d got a=%0b b=%0b exp a=%0b b=%0b",
                             t, a_ready, b_ready, t[0] == 1'b0, t[0] == 1'b1);
                end
            end else begin
                a_valid = 0; b_valid = 0;
            end
            step();
        end
        checks++; if (n !== 6) begin errors++; $display("FAIL contention_count got %0d exp 6", n); end
    endtask

    task automatic test_div0();
        b_valid = 1; b_op1 = 5; b_op2 = 0;
        #1;
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL div0_b_ready got %0b exp 1", b_ready); end
        step();
        b_valid = 0;
        for (int k = 2; k <= LAT; k++) step();
        checks++; if (res_valid !== 1'b1 || res_div0 !== 1'b1) begin errors++; $display("FAIL div0_flag got valid %0b div0 %0b exp 1 1", res_valid, res_div0); end
        checks++; if (res_quotient !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_quotient got %0h exp ffffffff", res_quotient); end
        checks++; if (res_fractional !== 5) begin errors++; $display("FAIL div0_fractional got %0d exp 5", res_fractional); end
        checks++; if (res_src !== 1'b1) begin errors++; $display("FAIL div0_src got %0b exp 1", res_src); end
        step();
    endtask

    task automatic test_back_pressure();
        int o1 [3] = '{20, 50, 77};
        int o2 [3] = '{3, 5, 4};
        int eq [3] = '{6, 10, 19};
        int er [3] = '{2, 0, 1};
        int n = 0;
        int waited = 0;
        for (int i = 0; i < 3; i++) begin
            a_valid = 1; a_op1 = o1[i]; a_op2 = o2[i];
            step();
        end
        a_valid = 0;
        while (res_valid !== 1'b1 && waited < 10) begin
            step();
            waited++;
        end
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL bp_first_result got valid %0b exp 1", res_valid); end
        res_ready = 0;
        a_valid = 1; a_op1 = 99; a_op2 = 9;
        b_valid = 1; b_op1 = 88; b_op2 = 8;
        for (int s = 0; s < 4; s++) begin
            if (s > 0) step();
            #1;
            checks++;
            if (core_ce !== 1'b0 || a_ready !== 1'b0 || b_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall cycle %0d got ce=%0b a=%0b b=%0b exp 0 0 0", s, core_ce, a_ready, b_ready);
            end
            checks++;
            if (res_valid !== 1'b1 || res_quotient !== 6 || res_fractional !== 2 || res_src !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got v=%0b q=%0d r=%0d exp v=1 q=6 r=2", s, res_valid, res_quotient, res_fractional);
            end
        end
        step();
        a_valid = 0; b_valid = 0;
        res_ready = 1;
        for (int t = 0; t < 12; t++) begin
            if (res_valid === 1'b1) begin
                if (n < 3) begin
                    checks++;
                    if (res_quotient !== eq[n] || res_fractional !== er[n]) begin
                        errors++;
                        $display("FAIL bp_result %0d got q=%0d r=%0d exp q=%0d r=%0d", n, res_quotient, res_fractional, eq[n], er[n]);
                    end
                end
                n++;
            end
            step();
        end
        checks++; if (n !== 3) begin errors++; $display("FAIL bp_count got %0d exp 3", n); end
    endtask

    task automatic test_rfd();
        core_rfd = 0;
        a_valid = 1; a_op1 = 9; a_op2 = 2;
        for (int s = 0; s < 3; s++) begin
            #1;
            checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL rfd_blocked cycle %0d got %0b exp 0", s, a_ready); end
            step();
        end
        core_rfd = 1;
        #1;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL rfd_accept got %0b exp 1", a_ready); end
        step();
        a_valid = 0;
        for (int k = 2; k <= LAT; k++) step();
        checks++;
        if (res_valid !== 1'b1 || res_quotient !== 4 || res_fractional !== 1) begin
            errors++;
            $display("FAIL rfd_result got v=%0b q=%0d r=%0d exp v=1 q=4 r=1", res_valid, res_quotient, res_fractional);
        end
        step();
    endtask

    task automatic test_reset_midflight();
        int stale = 0;
        for (int i = 0; i < 4; i++) begin
            a_valid = 1; a_op1 = 40 + i; a_op2 = 3;
            step();
        end
        a_valid = 0;
        checks++; if (res_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL mid_inflight got v=%0b busy=%0b exp 1 1", res_valid, busy); end
        #2;
        RST = 1'b1;
        #1;
        checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset_drop got v=%0b busy=%0b exp 0 0", res_valid, busy); end
        checks++; if (core_ce !== 1'b1) begin errors++; $display("FAIL mid_reset_ce got %0b exp 1", core_ce); end
        step();
        step();
        RST = 1'b0;
        for (int t = 0; t < 2 * LAT; t++) begin
            if (res_valid !== 1'b0 || busy !== 1'b0) stale++;
            step();
        end
        checks++; if (stale !== 0) begin errors++; $display("FAIL mid_stale got %0d exp 0", stale); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_div0();
        test_back_pressure();
        test_rfd();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
